// File: rtl/mux_dff_arbiter.sv
// Two-requester round-robin arbiter owning a single muxed capture register.
// The owner's data is captured each cycle it requests; MAX_HOLD bounds ownership under contention.
module mux_dff_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [3:0]       hold_cnt
);

  localparam int unsigned   CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(15);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_last;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_valid;
  logic [CNT_W-1:0]   r_hold;

  logic               w_own1;
  logic               w_req_own;
  logic               w_req_oth;
  logic [WIDTH-1:0]   w_d_own;
  logic [CNT_W-1:0]   w_cnt_inc;
  state_t             w_other;

  // Fold GRANT0/GRANT1 into "owner" and "other" views so one branch serves both.
  always_comb begin
    w_own1    = (r_state == GRANT1);
    w_req_own = w_own1 ? req1 : req0;
    w_req_oth = w_own1 ? req0 : req1;
    w_d_own   = w_own1 ? d1 : d0;
    w_other   = w_own1 ? GRANT0 : GRANT1;
    w_cnt_inc = (r_hold == CNT_MAX) ? r_hold : r_hold + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_hold    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_q_valid <= 1'b0;
          r_hold    <= '0;
          if (req0 && req1) begin
            r_state <= r_last ? GRANT0 : GRANT1;
          end else if (req0) begin
            r_state <= GRANT0;
          end else if (req1) begin
            r_state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (w_req_own) begin
            r_q       <= w_d_own;
            r_q_valid <= 1'b1;
            // Forced rotation uses the count including this edge's capture.
            if (w_req_oth && (w_cnt_inc >= HOLD_LIM)) begin
              r_state <= w_other;
              r_last  <= w_own1;
              r_hold  <= '0;
            end else begin
              r_hold  <= w_cnt_inc;
            end
          end else begin
            r_q_valid <= 1'b0;
            r_state   <= w_req_oth ? w_other : IDLE;
            r_last    <= w_own1;
            r_hold    <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_q_valid <= 1'b0;
          r_hold    <= '0;
        end
      endcase
    end
  end

  assign gnt0     = (r_state == GRANT0);
  assign gnt1     = (r_state == GRANT1);
  assign sel      = (r_state == GRANT1);
  assign q        = r_q;
  assign q_valid  = r_q_valid;
  assign hold_cnt = r_hold;

endmodule

// File: tb/tb_mux_dff_arbiter.sv
// Directed bench for mux_dff_arbiter: vector table plus reset, sampling and saturation sequences.
module tb_mux_dff_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [0:0] d0, d1;
  logic       gnt0, gnt1, sel;
  logic [0:0] q;
  logic       q_valid;
  logic [3:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  mux_dff_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .d0       (d0),
    .d1       (d1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .sel      (sel),
    .q        (q),
    .q_valid  (q_valid),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       r0, r1, d0, d1;
    logic       g0, g1, sl, q, qv;
    logic [3:0] hc;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r0, r1, di0, di1, g0, g1, qq, qv, input int hc);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = di0; v.d1 = di1;
    v.g0 = g0; v.g1 = g1; v.sl = g1; v.q = qq; v.qv = qv;
    v.hc = 4'(hc);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic g0, g1, qq, qv, input int hc);
    chk({tag, ".gnt0"},     32'(gnt0),     32'(g0));
    chk({tag, ".gnt1"},     32'(gnt1),     32'(g1));
    chk({tag, ".sel"},      32'(sel),      32'(g1));
    chk({tag, ".q"},        32'(q),        32'(qq));
    chk({tag, ".q_valid"},  32'(q_valid),  32'(qv));
    chk({tag, ".hold_cnt"}, 32'(hold_cnt), hc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              r0 r1 d0 d1   g0 g1 q qv hc
    vecs[0]  = mk(1, 0, 1, 0,   1, 0, 0, 0, 0);  // IDLE -> GRANT0
    vecs[1]  = mk(1, 0, 1, 0,   1, 0, 1, 1, 1);
    vecs[2]  = mk(1, 0, 1, 0,   1, 0, 1, 1, 2);
    vecs[3]  = mk(1, 0, 1, 0,   1, 0, 1, 1, 3);
    vecs[4]  = mk(1, 0, 1, 0,   1, 0, 1, 1, 4);
    vecs[5]  = mk(1, 0, 1, 0,   1, 0, 1, 1, 5);
    vecs[6]  = mk(1, 0, 1, 0,   1, 0, 1, 1, 6);  // no rotation without contention
    vecs[7]  = mk(0, 0, 0, 0,   0, 0, 1, 0, 0);  // release -> IDLE, q holds
    vecs[8]  = mk(0, 0, 0, 0,   0, 0, 1, 0, 0);
    vecs[9]  = mk(1, 1, 0, 0,   0, 1, 1, 0, 0);  // tie, last_served=0 -> requester 1
    vecs[10] = mk(1, 1, 0, 0,   0, 1, 0, 1, 1);
    vecs[11] = mk(1, 1, 0, 1,   0, 1, 1, 1, 2);
    vecs[12] = mk(1, 0, 0, 0,   1, 0, 1, 0, 0);  // early release, no capture
    vecs[13] = mk(1, 1, 1, 0,   1, 0, 1, 1, 1);
    vecs[14] = mk(1, 1, 1, 0,   1, 0, 1, 1, 2);
    vecs[15] = mk(1, 1, 1, 0,   1, 0, 1, 1, 3);
    vecs[16] = mk(1, 1, 1, 0,   0, 1, 1, 1, 0);  // 4th capture + same-edge switch
    vecs[17] = mk(1, 1, 1, 0,   0, 1, 0, 1, 1);
    vecs[18] = mk(1, 1, 1, 0,   0, 1, 0, 1, 2);
    vecs[19] = mk(1, 1, 1, 0,   0, 1, 0, 1, 3);
    vecs[20] = mk(1, 1, 1, 0,   1, 0, 0, 1, 0);  // back to requester 0
    vecs[21] = mk(1, 1, 1, 0,   1, 0, 1, 1, 1);
    vecs[22] = mk(1, 0, 0, 0,   1, 0, 0, 1, 2);
    vecs[23] = mk(0, 1, 0, 0,   0, 1, 0, 0, 0);  // owner drops, other waiting
    vecs[24] = mk(0, 0, 0, 0,   0, 0, 0, 0, 0);

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0;
    #12;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req0 = vecs[i].r0; req1 = vecs[i].r1; d0 = vecs[i].d0; d1 = vecs[i].d1;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].q, vecs[i].qv, int'(vecs[i].hc));
    end

    // Asynchronous reset mid-grant with q=1.
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b0; d0 = 1'b1;
    step(); step(); step();
    chk_all("pre_rst", 1'b1, 1'b0, 1'b1, 1'b1, 2);
    #2 rst = 1'b0;
    #1 chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    rst = 1'b1;
    step();
    chk_all("post_rst_tie", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Only the value at the edge is captured; d1 is ignored while sel=0.
    @(negedge clk);
    req1 = 1'b0;
    d0 = 1'b0; d1 = 1'b0; #1 d0 = 1'b1; d1 = 1'b1; #1 d0 = 1'b0; #1 d0 = 1'b1; d1 = 1'b0;
    step();
    chk("sample_d0_hi.q", 32'(q), 1);
    chk("sample_d0_hi.qv", 32'(q_valid), 1);
    @(negedge clk);
    d0 = 1'b1; d1 = 1'b0; #1 d0 = 1'b0; d1 = 1'b1;
    step();
    chk("sample_d0_lo.q", 32'(q), 0);
    @(negedge clk);
    d0 = 1'b0; d1 = 1'b1;
    step();
    chk("d1_ignored.q", 32'(q), 0);
    chk("d1_ignored.sel", 32'(sel), 0);

    // hold_cnt saturates at 15 with a lone requester.
    for (int i = 0; i < 16; i++) step();
    chk("hold_sat.hold_cnt", 32'(hold_cnt), 15);
    chk("hold_sat.gnt0", 32'(gnt0), 1);
    step();
    chk("hold_sat2.hold_cnt", 32'(hold_cnt), 15);

    // req1 alone rising while requester 0 holds past MAX_HOLD forces rotation next edge.
    @(negedge clk);
    req1 = 1'b1; d1 = 1'b1;
    step();
    chk("sat_rotate.gnt1", 32'(gnt1), 1);
    chk("sat_rotate.hold_cnt", 32'(hold_cnt), 0);
    chk("sat_rotate.qv", 32'(q_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_dff_arbiter.md
Name: mux_dff_arbiter

Overview:
- Two-requester round-robin arbiter that shares a single muxed capture register, equivalent to the d0/d1/sel mux-flop datapath.
- Each requester drives a request and a data word. The arbiter grants one requester at a time, drives the mux select, and captures the granted requester's data into q.
- A hold limit bounds how long one requester may own the register while the other is waiting.
- Sits between two producer blocks and the shared register stage.

Parameters:
WIDTH, 1, data width of d0/d1/q
MAX_HOLD, 4, maximum consecutive capture cycles per grant while the other requester is waiting (legal range 1..15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req0  input  1  requester 0 request; level, held while it wants the register
req1  input  1  requester 1 request
d0  input  WIDTH  requester 0 data
d1  input  WIDTH  requester 1 data
gnt0  output  1  registered grant to requester 0
gnt1  output  1  registered grant to requester 1
sel  output  1  registered mux select; 1 iff requester 1 owns the register
q  output  WIDTH  captured data register
q_valid  output  1  one-cycle pulse per capture; high when q was written at the preceding edge
hold_cnt  output  4  captures performed in the current grant (debug/observability)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, gnt0=gnt1=0, sel=0, q=0, q_valid=0, hold_cnt=0, last_served=1, so requester 0 wins the first tie. Reset asserted mid-grant aborts immediately with no capture. The first edge after rst rises evaluates normally.
- States: IDLE, GRANT0, GRANT1. Outputs are decoded from registered state:
  - gnt0 = (state==GRANT0)
  - gnt1 = (state==GRANT1)
  - sel = (state==GRANT1)
- gnt0 and gnt1 are never high together.
- IDLE, evaluated at each edge:
  - req0 & req1: grant the requester != last_served.
  - Only reqX: go to GRANTX.
  - None: stay in IDLE.
  - Grant latency: request sampled high at edge k gives gntX high after edge k.
- GRANTX, evaluated at each edge:
  - If reqX=1: q <= dX, q_valid <= 1, hold_cnt <= hold_cnt+1 (saturating at 15).
  - If reqX=0: no capture, q holds, q_valid <= 0.
- Next state from GRANTX (Y = other requester), with cnt = hold_cnt after this edge's increment:
  - reqX=0 and reqY=1: go to GRANTY.
  - reqX=0 and reqY=0: go to IDLE.
  - reqX=1, reqY=1 and cnt >= MAX_HOLD: go to GRANTY (forced rotation).
  - Otherwise stay in GRANTX; with reqY=0 the grant is held indefinitely.
- On any exit from GRANTX: last_served <= X, hold_cnt <= 0.
- A GRANTX to GRANTY switch happens in a single edge, with no idle cycle. gntX falls and gntY rises at the same edge.
- q_valid is 0 at every edge without a capture. q changes only on capture edges.
- The capture uses the d value sampled at the edge. Data changes between edges have no effect.
- The arbiter ignores reqX rising while in GRANTY until rotation; requests are not queued beyond the level.
- MAX_HOLD=1: strict alternation whenever both requesters request continuously.

Test Plan:
- Reset: rst=0 mid-grant with q=1 → immediately gnt0=gnt1=0, q=0, q_valid=0, sel=0. rst=1 with req0=req1=1 → gnt0=1 after the next edge.
- Single requester: req0=1, d0=1 for 6 cycles, req1=0 → gnt0 held all 6 cycles; q=1 with q_valid=1 on each of the 6 capture edges; hold_cnt counts to 6 with no rotation.
- Round-robin tie: req0=req1=1 from reset, MAX_HOLD=4, d0=1, d1=0 → 4 captures of 1 with sel=0, then a same-edge switch (gnt0→0, gnt1→1, sel=1), 4 captures of 0, then back to gnt0.
- Early release: in GRANT1, drop req1 after 2 captures with req0=1 → next edge gnt1=0, gnt0=1, no capture that edge (q_valid=0), hold_cnt=0.
- Idle return and fairness: req0 only, release → IDLE (q holds, q_valid=0). Then req0=req1=1 simultaneously → gnt1 wins because last_served=0.
- Data sampling: in GRANT0, toggle d0 between edges to 0→1→0, stable 1 at the edge → q=1; d1 changes never affect q while sel=0.
